// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the requester count, the select width, the FSM state type and a one-hot helper.
package arb_pkg;

    localparam int NREQ = 32;
    localparam int SW   = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [SW-1:0] arb_sel_t;

    function automatic logic [NREQ-1:0] onehot(input arb_sel_t s);
        return NREQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational rotating priority search: finds the first set request bit at or above start,
// wrapping from the top index back to 0.
import arb_pkg::*;

module rr_pick (
    input  logic [NREQ-1:0] req,
    input  arb_sel_t        start,
    output logic            found,
    output arb_sel_t        idx
);

    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[start + SW'(i)]) begin
                found = 1'b1;
                idx   = start + SW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 32:1 mux (control only).
// Optional stall timeout with forced release is built when ARB_TIMEOUT_EN is defined.
import arb_pkg::*;

module rr_mux_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_lock,
    output logic [NREQ-1:0] req_ready,
    output arb_sel_t        sel,
    output logic [NREQ-1:0] grant,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            timeout_err
);

    arb_state_t      r_state, w_state_nxt;
    arb_sel_t        r_sel, w_sel_nxt;
    arb_sel_t        r_ptr, w_ptr_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;

    logic [NREQ-1:0] w_pick_req;
    arb_sel_t        w_pick_start;
    arb_sel_t        w_pick_idx;
    logic            w_pick_found;
    logic            w_xfer;
    logic            w_timeout;

    assign out_valid   = (r_state == GRANT) & req_valid[r_sel];
    assign req_ready   = r_grant & {NREQ{out_ready}};
    assign sel         = r_sel;
    assign grant       = r_grant;
    assign w_xfer      = out_valid & out_ready;
    assign timeout_err = w_timeout;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_stall_cnt;
    logic       w_stall;

    assign w_stall   = out_valid & ~out_ready;
    assign w_timeout = w_stall & (r_stall_cnt == 8'(TIMEOUT - 1));

    // Any non-stall cycle is a transfer, a release or idle time, so the count restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end else begin
            r_stall_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    rr_pick u_pick (
        .req   (w_pick_req),
        .start (w_pick_start),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = r_grant;
        w_pick_req   = req_valid;
        w_pick_start = r_ptr;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_pick_idx;
                    w_grant_nxt = onehot(w_pick_idx);
                end
            end
            GRANT: begin
                // The current owner is excluded from the search; if nobody else wants the
                // mux it keeps the grant so a lone requester streams at full rate.
                w_pick_req   = req_valid & ~r_grant;
                w_pick_start = r_sel + SW'(1);
                if (!req_valid[r_sel] || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_sel + SW'(1);
                end else if (w_xfer) begin
                    w_ptr_nxt = r_sel + SW'(1);
                    if (!req_lock[r_sel] && w_pick_found) begin
                        w_sel_nxt   = w_pick_idx;
                        w_grant_nxt = onehot(w_pick_idx);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic,
// all compared against an integer-level round-robin reference model.
module tb_rr_mux_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_valid;
    logic [31:0] req_lock;
    logic [31:0] req_ready;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        out_valid;
    logic        out_ready;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_granted = 1'b0;
    int m_sel     = 0;
    int m_ptr     = 0;
    int m_stall   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .sel         (sel),
        .grant       (grant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // First set bit among n candidates starting at index start (mod 32), or -1.
    function automatic int first_from(input logic [31:0] r, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(start + k) % 32]) return (start + k) % 32;
        end
        return -1;
    endfunction

    function automatic bit m_stalling();
        return m_granted && req_valid[m_sel] && !out_ready;
    endfunction

    function automatic bit m_to_err();
`ifdef ARB_TIMEOUT_EN
        return m_stalling() && (m_stall == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int w;
        bit to;
        to = m_to_err();
        if (rst) begin
            m_granted = 1'b0; m_sel = 0; m_ptr = 0; m_stall = 0;
        end else begin
            if (m_stalling() && !to) m_stall++;
            else m_stall = 0;
            if (!m_granted) begin
                w = first_from(req_valid, m_ptr, 32);
                if (w >= 0) begin m_granted = 1'b1; m_sel = w; end
            end else if (!req_valid[m_sel] || to) begin
                m_granted = 1'b0;
                m_ptr = (m_sel + 1) % 32;
            end else if (out_ready) begin
                m_ptr = (m_sel + 1) % 32;
                if (!req_lock[m_sel]) begin
                    w = first_from(req_valid, m_sel + 1, 31);
                    if (w >= 0) m_sel = w;
                end
            end
        end
    endtask

    // One clock: compare outputs mid-cycle, advance model at the edge, return at negedge.
    task automatic cyc();
        logic [31:0] eg, er, ev, es, et;
        #1;
        eg = m_granted ? (32'h1 << m_sel) : 32'h0;
        er = (m_granted && out_ready) ? (32'h1 << m_sel) : 32'h0;
        ev = {31'd0, m_granted && req_valid[m_sel]};
        es = m_sel;
        et = {31'd0, m_to_err()};
        chk("grant", grant, eg);
        chk("req_ready", req_ready, er);
        chk("out_valid", {31'd0, out_valid}, ev);
        chk("sel", {27'd0, sel}, es);
        chk("timeout_err", {31'd0, timeout_err}, et);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 32'hFFFF_FFFF; req_lock = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with every requester active
        repeat (2) cyc();
        chk("rst_grant", grant, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_sel", {27'd0, sel}, 32'h0);
        rst = 1'b0;
        cyc();
        chk("first_grant", grant, 32'h1);
        chk("first_sel", {27'd0, sel}, 32'h0);

        // Fairness between requesters 0 and 31, no bubbles
        req_valid = 32'h8000_0001; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("fair_sel", {27'd0, sel}, (k % 2 == 0) ? 32'd31 : 32'd0);
            chk("fair_valid", {31'd0, out_valid}, 32'h1);
        end
        req_valid = '0;
        repeat (2) cyc();

        // Wrap: leave ptr at 30, then requesters 2 and 29
        req_valid = 32'h2000_0000;
        repeat (2) cyc();
        req_valid = '0;
        cyc();
        req_valid = 32'h2000_0004; out_ready = 1'b0;
        cyc();
        chk("wrap_first", {27'd0, sel}, 32'd2);
        out_ready = 1'b1;
        cyc();
        chk("wrap_second", {27'd0, sel}, 32'd29);
        req_valid = '0; out_ready = 1'b0;
        repeat (2) cyc();

        // Backpressure on requester 7
        req_valid = 32'h0000_0080;
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_sel", {27'd0, sel}, 32'd7);
            chk("bp_valid", {31'd0, out_valid}, 32'h1);
            chk("bp_ready", req_ready, 32'h0);
        end
        out_ready = 1'b1;
        #1 chk("bp_xfer_ready", req_ready, 32'h0000_0080);
        cyc();
        req_valid = '0; out_ready = 1'b0;
        repeat (2) cyc();
        chk("bp_after_ready", req_ready, 32'h0);

        // Lock on requester 4 with requester 5 waiting
        req_valid = 32'h0000_0030; req_lock = 32'h0000_0010;
        cyc();
        chk("lock_grant", {27'd0, sel}, 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("lock_hold", {27'd0, sel}, 32'd4);
        end
        req_lock = '0;
        cyc();
        chk("lock_move", {27'd0, sel}, 32'd5);
        req_valid = '0; out_ready = 1'b0;
        repeat (2) cyc();

`ifdef ARB_TIMEOUT_EN
        // Stall on requester 9 until forced release, requester 10 waiting
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 32'h0000_0200;
        cyc();
        req_valid = 32'h0000_0600;
        repeat (8) cyc();
        req_valid = '0;
        repeat (2) cyc();
`endif

        // Randomized traffic, mostly holding requests, occasional reset
        for (int k = 0; k < 400; k++) begin
            req_valid = (req_valid & ~($urandom & $urandom & $urandom))
                      | ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) req_valid = $urandom;
            req_lock  = $urandom & $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 60) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
